osc_reset_sequencer: RTL



---
 rtl/osc_reset_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/osc_reset_sequencer.sv
// Power-up reset sequencer: sync inputs, filter PLL lock, release fabric then video reset after a stagger.
// Outputs registered from next state; no backpressure. Optional watchdog/FAULT path under OSC_RST_SEQ_WDOG_EN.
module osc_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FILTER    = 16,
    parameter int HOLD_CYCLES    = 200,
    parameter int STAGGER_CYCLES = 20,
    parameter int WDOG_CYCLES    = 20000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INIT_DONE,
    input  logic       PLL_LOCK,
    input  logic       EXT_RST_N,
    output logic       FABRIC_RESET_N,
    output logic       VIDEO_RESET_N,
    output logic       READY,
    output logic [2:0] SEQ_STATE,
    output logic       WDOG_FAULT
);

    localparam int SEQ_MAX0 = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int SEQ_MAX  = (SEQ_MAX0 > STAGGER_CYCLES) ? SEQ_MAX0 : STAGGER_CYCLES;
    localparam int CNT_W    = $clog2(SEQ_MAX) + 1;

    if (SYNC_STAGES < 2 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("osc_reset_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WAIT_LOCK = 3'd2,
        HOLD      = 3'd3,
        REL_FAB   = 3'd4,
        RUN       = 3'd5,
        FAULT     = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] init_sync_q, init_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic                   fab_rst_n_q, fab_rst_n_d;
    logic                   vid_rst_n_q, vid_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   init_s, lock_s, ext_s;

    assign init_s = init_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign ext_s  = ext_sync_q[SYNC_STAGES-1];

    always_comb begin
        init_sync_d = {init_sync_q[SYNC_STAGES-2:0], INIT_DONE};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
        ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], EXT_RST_N};
    end

`ifdef OSC_RST_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            wdog_fault_q, wdog_fault_d;
    logic            wdog_expired;

    assign wdog_expired = (state_q == WAIT_INIT || state_q == WAIT_LOCK) &&
                          (wdog_q == WD_W'(WDOG_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (ext_s) state_d = WAIT_INIT;
            WAIT_INIT: if (init_s) state_d = WAIT_LOCK;
            WAIT_LOCK: if (lock_s && cnt_q == CNT_W'(LOCK_FILTER - 1)) state_d = HOLD;
            HOLD:      if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = REL_FAB;
            REL_FAB:   if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) state_d = RUN;
            RUN:       state_d = RUN;
            FAULT:     if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
`ifdef OSC_RST_SEQ_WDOG_EN
        if (wdog_expired) state_d = FAULT;
`endif
        // Lock loss and external request override everything, ext last so it wins.
        if (!lock_s && (state_q == HOLD || state_q == REL_FAB || state_q == RUN)) state_d = WAIT_LOCK;
        if (!ext_s) state_d = IDLE;

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT_LOCK && !lock_s) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        fab_rst_n_d = (state_d == REL_FAB) || (state_d == RUN);
        vid_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
    end

`ifdef OSC_RST_SEQ_WDOG_EN
    always_comb begin
        wdog_d = '0;
        if ((state_q == WAIT_INIT || state_q == WAIT_LOCK) &&
            (state_d == WAIT_INIT || state_d == WAIT_LOCK)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        wdog_fault_d = wdog_fault_q | (state_d == FAULT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wdog_q       <= '0;
            wdog_fault_q <= 1'b0;
        end else begin
            wdog_q       <= wdog_d;
            wdog_fault_q <= wdog_fault_d;
        end
    end

    assign WDOG_FAULT = wdog_fault_q;
`else
    assign WDOG_FAULT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            init_sync_q <= '0;
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
            fab_rst_n_q <= 1'b0;
            vid_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_sync_q <= init_sync_d;
            lock_sync_q <= lock_sync_d;
            ext_sync_q  <= ext_sync_d;
            fab_rst_n_q <= fab_rst_n_d;
            vid_rst_n_q <= vid_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign FABRIC_RESET_N = fab_rst_n_q;
    assign VIDEO_RESET_N  = vid_rst_n_q;
    assign READY          = ready_q;
    assign SEQ_STATE      = state_q;

endmodule
